// File: rtl/wbus_target.sv
// rtl/wbus_target.sv - W-bus write target: write FIFO draining into a single-port register bank with a local read port.
// Optional WBUS_TARGET_DROP_CNT_EN adds a saturating drop_cnt output.
module wbus_target #(
  parameter int          DEPTH     = 4,
  parameter int          REGS      = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                wa_addr,
  input  logic [15:0]                wa_data_wr,
  input  logic                       wa_wr_s,
  input  logic                       rd_en,
  input  logic [$clog2(REGS)-1:0]    rd_addr,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef WBUS_TARGET_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int AW = $clog2(REGS);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = AW + 16;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [15:0]   bank [REGS];

  logic          in_range;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] head;

  // BASE_ADDR is aligned to REGS, so only the upper address bits decide the hit.
  assign in_range = (wa_addr[15:AW] == BASE_ADDR[15:AW]);
  assign full     = (fifo_level == FULL_LEVEL);
  assign pop      = (fifo_level != '0) && !rd_en;
  assign push     = wa_wr_s && in_range && (!full || pop);
  assign drop     = wa_wr_s && in_range && full && !pop;
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {wa_addr[AW-1:0], wa_data_wr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Single-port bank: a drain only happens in cycles without a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        bank[i] <= 16'h0;
      end
    end else if (pop) begin
      bank[head[EW-1:16]] <= head[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= 16'h0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= bank[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef WBUS_TARGET_DROP_CNT_EN
  // A drop coinciding with a clear is counted as the first drop after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 8'h1 : 8'h0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'h1;
    end
  end
`endif

endmodule

// File: tb/tb_wbus_target.sv
// tb/tb_wbus_target.sv - scoreboard bench for wbus_target (DEPTH=4, REGS=16, BASE_ADDR=0).
module tb_wbus_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wa_addr = 16'h0;
  logic [15:0] wa_data_wr = 16'h0;
  logic        wa_wr_s = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  fifo_level;
  logic        ovf;
  logic        ovf_clr = 1'b0;
`ifdef WBUS_TARGET_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  wbus_target #(.DEPTH(4), .REGS(16), .BASE_ADDR(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .wa_addr    (wa_addr),
    .wa_data_wr (wa_data_wr),
    .wa_wr_s    (wa_wr_s),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef WBUS_TARGET_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read monitor: every rd_valid pulse consumes the oldest expected read value.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %h expected no read", rd_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  // One clock cycle of stimulus; inputs return to idle afterwards.
  task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic r, input logic [3:0] ra, input logic [15:0] rexp);
    wa_wr_s = w; wa_addr = a; wa_data_wr = d;
    rd_en = r; rd_addr = ra;
    if (r) exp_q.push_back(rexp);
    @(posedge clk); #1;
    wa_wr_s = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic rd(input logic [3:0] ra, input logic [15:0] e);
    step(1'b0, 16'h0, 16'h0, 1'b1, ra, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_level", 16'(fifo_level), 16'h0);
    chk("reset_ovf", 16'(ovf), 16'h0);
    chk("reset_rd_valid", 16'(rd_valid), 16'h0);
    chk("reset_rd_data", rd_data, 16'h0);

    // Single write then read two cycles later
    wr(16'h0003, 16'hBEEF);
    chk("t1_level_after_push", 16'(fifo_level), 16'h1);
    idle(1);
    chk("t1_level_drained", 16'(fifo_level), 16'h0);
    rd(4'd3, 16'hBEEF);
    idle(1);
    chk("t1_level_end", 16'(fifo_level), 16'h0);

    // Out-of-range write is ignored
    do_reset();
    wr(16'h0010, 16'h1234);
    chk("t2_level", 16'(fifo_level), 16'h0);
    idle(1);
    chk("t2_ovf", 16'(ovf), 16'h0);
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0);
    idle(2);

    // Overflow while reads stall the drain
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i), 16'(i + 1), 1'b1, 4'd15, 16'h0);
    chk("t3_level_full", 16'(fifo_level), 16'h4);
    chk("t3_ovf_set", 16'(ovf), 16'h1);
`ifdef WBUS_TARGET_DROP_CNT_EN
    chk("t3_drop_cnt", 16'(drop_cnt), 16'h1);
`endif
    idle(4);
    chk("t3_level_drained", 16'(fifo_level), 16'h0);
    chk("t3_ovf_sticky", 16'(ovf), 16'h1);
    rd(4'd0, 16'h0001);
    rd(4'd1, 16'h0002);
    rd(4'd2, 16'h0003);
    rd(4'd3, 16'h0004);
    rd(4'd4, 16'h0000);
    ovf_clr = 1'b1;
    idle(1);
    chk("t3_ovf_cleared", 16'(ovf), 16'h0);
`ifdef WBUS_TARGET_DROP_CNT_EN
    chk("t3_drop_cnt_cleared", 16'(drop_cnt), 16'h0);
`endif

    // Continuous writes at full throughput
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr(16'(i % 16), 16'h0100 + 16'(i));
      chk("t4_level_le1", 16'(fifo_level <= 3'd1), 16'h1);
    end
    idle(1);
    chk("t4_ovf", 16'(ovf), 16'h0);
    chk("t4_level_end", 16'(fifo_level), 16'h0);
    for (int r = 0; r < 16; r++) rd(4'(r), 16'h0100 + 16'((r < 4) ? r + 16 : r));
    idle(2);

    // Read in the cycle right after a write sees the old value
    do_reset();
    wr(16'h0002, 16'h1111);
    rd(4'd2, 16'h0000);
    idle(1);
    rd(4'd2, 16'h1111);
    idle(2);

    // Reset while FIFO holds pending writes
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i), 16'hA000 + 16'(i), 1'b1, 4'd9, 16'h0);
    chk("t6_level_pre", 16'(fifo_level), 16'h3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_level_async", 16'(fifo_level), 16'h0);
    chk("t6_rd_data", rd_data, 16'h0);
    chk("t6_ovf", 16'(ovf), 16'h0);
    chk("t6_rd_valid", 16'(rd_valid), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk("t6_level_post", 16'(fifo_level), 16'h0);
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0);
    idle(3);

    chk("pending_reads", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbus_target.md
# wbus_target

Receiving end of the W-bus write channel produced by the serial interface. Captures every W-bus write strobe into a small FIFO and drains it into a single-port register bank. The bank also serves a local read port, and reads have priority over draining. The block is the plausible downstream consumer of the W-bus and gives the bench a reference target whose contents can be read back and checked.

## Interface
Parameters:
- DEPTH, 4, write FIFO entries (power of two, ≥2)
- REGS, 16, register bank entries (power of two, ≤256)
- BASE_ADDR, 16'h0000, first W-bus address mapped to register 0 (aligned to REGS)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wa_addr  in  16  W-bus write address
- wa_data_wr  in  16  W-bus write data
- wa_wr_s  in  1  W-bus write strobe; one write per cycle while high
- rd_en  in  1  local read request
- rd_addr  in  clog2(REGS)  register index to read
- rd_data  out  16  read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- fifo_level  out  clog2(DEPTH+1)  current FIFO occupancy
- ovf  out  1  sticky flag: a write was dropped because the FIFO was full
- ovf_clr  in  1  clears ovf

## Operation
- In-range write: BASE_ADDR ≤ wa_addr < BASE_ADDR+REGS.
  - On wa_wr_s=1 with an in-range address, {wa_addr[clog2(REGS)-1:0], wa_data_wr} is pushed into the FIFO.
- Out-of-range write: silently ignored. No FIFO push, no ovf.
- Full rule: a push is accepted when level<DEPTH, or when a pop occurs in the same cycle. Otherwise the write is dropped and ovf is set.
- Drain: when level>0 and rd_en=0, the head entry is popped and written into the bank in the same cycle.
  - rd_en=1 stalls the drain for that cycle (single-port bank, read wins).
- Read: rd_en=1 in cycle N presents bank[rd_addr] on rd_data with rd_valid=1 in cycle N+1.
  - rd_data holds its value until the next read.
  - rd_valid is 0 whenever there was no read in the previous cycle.
- No forwarding: a read returns the bank contents, never FIFO contents. Pending writes are invisible until drained.
- Multiple writes to the same index drain in order, so the last write wins.
- ovf: set by a drop, cleared by ovf_clr. Set wins when both occur in the same cycle.
- FIFO uses wrapping read/write pointers of clog2(DEPTH) bits. The level counter is used for full/empty; no pointer-compare ambiguity.

## Timing
- Reset values: bank all 0, FIFO empty, fifo_level=0, rd_data=16'h0, rd_valid=0, ovf=0, drop counter 0.
- Reset asserted mid-operation clears everything immediately; pending FIFO writes are lost.
- Write-to-bank latency: a write sampled at edge N is written into the bank at edge N+1, provided rd_en=0 during cycle N+1.
  - Earliest read returning the new value is issued in cycle N+1 or later, after the drain edge.
  - Data appears at N+2 or later.
- Read latency: 1 cycle.
- Full throughput: one push and one pop per cycle; level stays constant.
- Each rd_en cycle adds one cycle of drain delay.
- fifo_level and ovf are registered and update on the edge following the causing event.

## Configuration
- WBUS_TARGET_DROP_CNT_EN defined:
  - Adds output drop_cnt [7:0].
  - drop_cnt is a saturating count (max 255) of writes dropped on full FIFO.
  - ovf_clr also clears drop_cnt.
- Not defined: no drop_cnt port and no counter logic; ovf behaviour is unchanged.

## Test plan
- Reset, then single write addr 16'h0003 data 16'hBEEF. rd_en at addr 3 two cycles later -> rd_data=16'hBEEF, rd_valid=1, fifo_level returns to 0.
- Write addr 16'h0010 with REGS=16, BASE_ADDR=0 -> no push, fifo_level stays 0, ovf=0, and all registers still read 0.
- Hold rd_en=1, then issue 5 back-to-back writes (data 1..5, addrs 0..4) with DEPTH=4 -> fifo_level=4, ovf=1. Drop rd_en -> regs 0..3 = 1..4, reg 4 = 0. With the macro defined, drop_cnt=1.
- Continuous writes with rd_en=0 for 20 cycles -> fifo_level never exceeds 1, ovf stays 0, and each register holds its last written value.
- Write addr 2 data 16'h1111, then rd_en addr 2 in the very next cycle -> read returns the old value 0 (drain stalled), and a subsequent read returns 16'h1111.
- Fill FIFO to 3, assert rst for one cycle -> fifo_level=0, rd_data=0, ovf=0, and all bank reads return 0.
